serial_add: RTL and testbench
=============================

SERIAL_ADD -- requirements
Module: serial_add

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the operand width in bits (legal range 2..32).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: the reset, asynchronous and active-low.
REQ-004 The block SHALL have port start, input, 1 bit: request to begin an addition; sampled only in IDLE.
REQ-005 The block SHALL have port a, input, WIDTH bits: addend, captured on the edge that accepts start.
REQ-006 The block SHALL have port b, input, WIDTH bits: addend, captured on the edge that accepts start.
REQ-007 The block SHALL have port carryin, input, 1 bit: initial carry, captured on the edge that accepts start.
REQ-008 The block SHALL have port busy, output, 1 bit: high while the state is RUN or DONE.
REQ-009 The block SHALL have port done, output, 1 bit: single-cycle pulse, high only in state DONE.
REQ-010 The block SHALL have port sum, output, WIDTH bits: the result; valid from done onward.
REQ-011 The block SHALL have port carryout, output, 1 bit: the final carry; valid from done onward.

Function
REQ-012 The block SHALL add bit-serially, LSB first, one bit per clock, forming one bit per RUN cycle from a full-adder cell (operand LSBs plus a carry register).
REQ-013 The block SHALL implement a three-state FSM with states IDLE, RUN and DONE.
REQ-014 In IDLE with start=1 at a rising edge, the block SHALL load a and b into shift registers, load carryin into the carry register, clear the bit counter, and enter RUN.
REQ-015 In IDLE with start=0, the block SHALL stay in IDLE and hold sum and carryout unchanged.
REQ-016 On each RUN edge, the block SHALL:
  - shift the computed bit into sum from the MSB side;
  - shift the operands right by one;
  - update the carry register;
  - increment the counter.
REQ-017 On the RUN edge where the counter equals WIDTH-1, the block SHALL enter DONE; done is therefore high in the cycle following the WIDTH-th edge after the accepting edge.
REQ-018 From DONE, the block SHALL return to IDLE on the next edge unconditionally.
REQ-019 Results SHALL satisfy {carryout,sum} = a + b + carryin, computed on WIDTH+1 bits with no overflow flag.
REQ-020 In DONE, carryout SHALL equal the carry register.
REQ-021 sum and carryout SHALL hold until the next accepted start.
REQ-022 start asserted in RUN or DONE SHALL be ignored; captured operands SHALL be unaffected.
REQ-023 A start held high continuously SHALL launch back-to-back operations, one every WIDTH+2 cycles.
REQ-024 sum SHALL show partial shift contents during RUN, and consumers SHALL treat it as valid only from done onward.

Reset
REQ-025 While rst_n=0, regardless of clk, the block SHALL force the following:
  - state IDLE;
  - busy=0 and done=0;
  - sum=0 and carryout=0;
  - operand registers, carry register and counter cleared.
REQ-026 Reset asserted mid-RUN SHALL discard the partial result, and done SHALL NOT pulse for that operation.
REQ-027 The first start accepted SHALL be the one sampled at the first rising edge after rst_n deasserts.

Structure
REQ-028 State encodings (IDLE=2'b00, RUN=2'b01, DONE=2'b10) SHALL live as localparams in shared include file serial_add_defs.vh.
REQ-029 The block SHALL instantiate one combinational sub-module, onebit_add, with ports:
  - inputs: carry, a, b;
  - outputs: s, carryout.
REQ-030 The block SHALL contain no other sub-modules; the counter width SHALL be derived from WIDTH.

Verification (WIDTH=8)
REQ-031 The bench SHALL apply a=0x00, b=0x00, carryin=0, start pulse -> busy for 9 cycles, done pulses once on the 8th edge after acceptance, sum=0x00, carryout=0.
REQ-032 The bench SHALL apply a=0x35, b=0x1C, carryin=0 -> sum=0x51, carryout=0; then a=0x35, b=0x1C, carryin=1 -> sum=0x52.
REQ-033 The bench SHALL apply a=0xFF, b=0x01, carryin=0 -> sum=0x00, carryout=1; then a=0xFF, b=0xFF, carryin=1 -> sum=0xFF, carryout=1.
REQ-034 The bench SHALL start a=0x10, b=0x20, then pulse start with a=0xAA, b=0x55 during RUN -> result sum=0x30, carryout=0; the second request is not executed.
REQ-035 The bench SHALL assert rst_n=0 on the 4th RUN cycle of a=0x7F, b=0x01 -> immediately busy=0, sum=0x00, no done; after release, a=0x7F, b=0x01 -> sum=0x80, carryout=0.
REQ-036 The bench SHALL hold start=1 for 30 cycles with fixed a=0x0F, b=0xF0 -> done pulses every 10 cycles, each sum=0xFF, carryout=0.

Source files
------------

// File: rtl/serial_add_pkg.sv
// Shared types for the bit-serial adder: FSM state enum built on the
// encodings from serial_add_defs.vh.
// No logic; types and constants only.
package serial_add_pkg;

    `include "serial_add_defs.vh"

    typedef enum logic [1:0] {
        S_IDLE = ST_IDLE,
        S_RUN  = ST_RUN,
        S_DONE = ST_DONE
    } state_t;

endpackage

// File: rtl/serial_add_defs.vh
// State encodings for the serial adder control FSM.
// Pulled into serial_add_pkg so every user sees one definition.
localparam logic [1:0] ST_IDLE = 2'b00;
localparam logic [1:0] ST_RUN  = 2'b01;
localparam logic [1:0] ST_DONE = 2'b10;

// File: rtl/serial_add_onebit_add.sv
// Full-adder cell: one sum bit and carry from two operand bits and a carry.
// Latency: purely combinational, zero cycles.
// Backpressure: none; output follows inputs.
module onebit_add (
    input  logic carry,
    input  logic a,
    input  logic b,
    output logic s,
    output logic carryout
);

    // Classic full-adder equations
    always_comb begin
        s        = a ^ b ^ carry;
        carryout = (a & b) | (a & carry) | (b & carry);
    end

endmodule

// File: rtl/serial_add.sv
// Bit-serial adder: {carryout,sum} = a + b + carryin, LSB first, one bit per clock.
// Latency: done pulses WIDTH+1 cycles after the accepting edge; busy spans WIDTH+1 cycles.
// Backpressure: start is only sampled in IDLE; requests while busy are dropped.
module serial_add
    import serial_add_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             carryin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             carryout
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    state_t           r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic             r_carry;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_sum;
    logic             r_cout;
    logic             r_busy;
    logic             r_done;

    logic             w_s;
    logic             w_c;

    // The single adder cell always works on the current operand LSBs
    onebit_add u_onebit_add (
        .carry    (r_carry),
        .a        (r_a[0]),
        .b        (r_b[0]),
        .s        (w_s),
        .carryout (w_c)
    );

    // Control FSM plus datapath shift registers; busy/done are registered
    // so they line up exactly with the state they describe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_a     <= a;
                        r_b     <= b;
                        r_carry <= carryin;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= S_RUN;
                    end
                end
                S_RUN: begin
                    // New bit enters at the MSB so the first (LSB) bit ends at bit 0
                    r_sum   <= {w_s, r_sum[WIDTH-1:1]};
                    r_a     <= r_a >> 1;
                    r_b     <= r_b >> 1;
                    r_carry <= w_c;
                    r_cnt   <= r_cnt + CW'(1);
                    if (r_cnt == LAST_BIT) begin
                        r_cout  <= w_c;
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign busy     = r_busy;
    assign done     = r_done;
    assign sum      = r_sum;
    assign carryout = r_cout;

endmodule

// File: tb/tb_serial_add.sv
// Directed bench for serial_add at WIDTH=8 with hand-computed results.
// Latency: checks done timing relative to the accepting edge.
// Backpressure: exercises start during RUN and start held continuously.
module tb_serial_add;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [7:0] a;
    logic [7:0] b;
    logic       carryin;
    logic       busy;
    logic       done;
    logic [7:0] sum;
    logic       carryout;

    int checks = 0;
    int errors = 0;

    serial_add #(.WIDTH(8)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .a        (a),
        .b        (b),
        .carryin  (carryin),
        .busy     (busy),
        .done     (done),
        .sum      (sum),
        .carryout (carryout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Present operands with start for one accepting edge, then drop start
    task automatic launch(input logic [7:0] va, input logic [7:0] vb, input logic vc);
        a       = va;
        b       = vb;
        carryin = vc;
        start   = 1'b1;
        @(posedge clk); #1;
        start   = 1'b0;
    endtask

    // Called just after the accepting edge; k counts edges since acceptance.
    // Returns the k at which done was first seen, busy cycles and done pulses.
    task automatic wait_done(input bit inject, output int lat, output int bsy, output int dn);
        lat = -1;
        bsy = 0;
        dn  = 0;
        for (int k = 0; k < 20; k++) begin
            if (busy) bsy++;
            if (done) begin
                dn++;
                if (lat < 0) lat = k;
            end
            if (!busy && k > 0) break;
            if (inject && k == 2) begin
                a       = 8'hAA;
                b       = 8'h55;
                carryin = 1'b1;
                start   = 1'b1;
            end
            if (inject && k == 3) start = 1'b0;
            @(posedge clk); #1;
        end
    endtask

    initial begin
        int lat, bsy, dn;
        int dcnt, last, first;

        rst_n   = 1'b0;
        start   = 1'b0;
        a       = 8'h00;
        b       = 8'h00;
        carryin = 1'b0;

        // Reset state, sampled mid-reset
        #12;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_sum", sum, 0);
        check("rst_cout", carryout, 0);
        rst_n = 1'b1;

        // 0+0: first edge after release accepts; timing of busy/done
        launch(8'h00, 8'h00, 1'b0);
        wait_done(1'b0, lat, bsy, dn);
        check("zero_lat", lat, 8);
        check("zero_busy_cycles", bsy, 9);
        check("zero_done_pulses", dn, 1);
        check("zero_sum", sum, 8'h00);
        check("zero_cout", carryout, 0);

        // 0x35+0x1C
        launch(8'h35, 8'h1C, 1'b0);
        wait_done(1'b0, lat, bsy, dn);
        check("p1_lat", lat, 8);
        check("p1_sum", sum, 8'h51);
        check("p1_cout", carryout, 0);

        // 0x35+0x1C+1
        launch(8'h35, 8'h1C, 1'b1);
        wait_done(1'b0, lat, bsy, dn);
        check("p2_sum", sum, 8'h52);
        check("p2_cout", carryout, 0);

        // 0xFF+0x01 wraps with carry out
        launch(8'hFF, 8'h01, 1'b0);
        wait_done(1'b0, lat, bsy, dn);
        check("wrap_sum", sum, 8'h00);
        check("wrap_cout", carryout, 1);

        // 0xFF+0xFF+1 = 0x1FF
        launch(8'hFF, 8'hFF, 1'b1);
        wait_done(1'b0, lat, bsy, dn);
        check("max_sum", sum, 8'hFF);
        check("max_cout", carryout, 1);

        // start during RUN must be ignored
        launch(8'h10, 8'h20, 1'b0);
        wait_done(1'b1, lat, bsy, dn);
        check("ign_lat", lat, 8);
        check("ign_done_pulses", dn, 1);
        check("ign_sum", sum, 8'h30);
        check("ign_cout", carryout, 0);
        repeat (2) @(posedge clk);
        #1;
        check("ign_idle_after", busy, 0);

        // Reset on the 4th RUN cycle
        launch(8'h7F, 8'h01, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        check("mid_busy_pre", busy, 1);
        rst_n = 1'b0;
        #1;
        check("mid_busy", busy, 0);
        check("mid_done", done, 0);
        check("mid_sum", sum, 8'h00);
        check("mid_cout", carryout, 0);
        dn = 0;
        repeat (3) begin
            @(posedge clk); #1;
            if (done) dn++;
        end
        rst_n = 1'b1;
        repeat (10) begin
            @(posedge clk); #1;
            if (done) dn++;
        end
        check("mid_no_done", dn, 0);
        check("mid_idle", busy, 0);
        launch(8'h7F, 8'h01, 1'b0);
        wait_done(1'b0, lat, bsy, dn);
        check("post_lat", lat, 8);
        check("post_sum", sum, 8'h80);
        check("post_cout", carryout, 0);

        // start held high: back-to-back every WIDTH+2 cycles
        a       = 8'h0F;
        b       = 8'hF0;
        carryin = 1'b0;
        start   = 1'b1;
        dcnt    = 0;
        last    = -1;
        first   = -1;
        for (int c = 1; c <= 30; c++) begin
            @(posedge clk); #1;
            if (done) begin
                dcnt++;
                check("held_sum", sum, 8'hFF);
                check("held_cout", carryout, 0);
                if (last >= 0) check("held_period", c - last, 10);
                if (first < 0) first = c;
                last = c;
            end
        end
        start = 1'b0;
        check("held_first", first, 9);
        check("held_count", dcnt, 3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
